// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// the queue entry layout and the pointer/count width helper.
package fetch_pkg;

    // Default geometry of the fetch path (64-bit PCs, 32-bit instructions).
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_INST_W = 32;

    // Bytes the PC advances per fetched instruction at the default width.
    localparam int INST_BYTES = DEF_INST_W / 8;

    // One fetch queue entry as seen by decode: the PC and its instruction.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
    } fetch_entry_t;

    // Width of a counter that must hold values 0..n inclusive (n a power of two).
    function automatic int clog2_plus1(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular fetch buffer with three pointers. An entry is allocated (PC
// written) when its request issues, filled (instruction written) when the
// in-order response returns, and freed when decode takes it. A flush drops
// every entry at once; reset has priority over flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             alloc_en,
    input  logic [ADDR_W-1:0]                alloc_pc,
    input  logic                             fill_en,
    input  logic [INST_W-1:0]                fill_inst,
    input  logic                             deq_en,
    output logic [clog2_plus1(DEPTH)-1:0]    occupancy,
    output logic [clog2_plus1(DEPTH)-1:0]    filled_cnt,
    output logic [ADDR_W-1:0]                head_pc,
    output logic [INST_W-1:0]                head_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = clog2_plus1(DEPTH);

    // Entry storage: PC and instruction halves are written at different times.
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] alloc_ptr_reg, alloc_ptr_next;
    logic [PTR_W-1:0] fill_ptr_reg,  fill_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg,    rd_ptr_next;
    logic [CNT_W-1:0] occ_reg,       occ_next;
    logic [CNT_W-1:0] filled_reg,    filled_next;

    logic alloc_wr;
    logic fill_wr;

    // Storage writes are suppressed in reset and flush cycles.
    assign alloc_wr = alloc_en && !rst && !flush;
    assign fill_wr  = fill_en  && !rst && !flush;

    // Write the PC half at allocation and the instruction half at fill.
    always_ff @(posedge clk) begin
        if (alloc_wr) begin
            pc_mem[alloc_ptr_reg] <= alloc_pc;
        end
        if (fill_wr) begin
            inst_mem[fill_ptr_reg] <= fill_inst;
        end
    end

    // The head entry is presented directly so decode sees it the cycle after fill.
    assign head_pc    = pc_mem[rd_ptr_reg];
    assign head_inst  = inst_mem[rd_ptr_reg];
    assign occupancy  = occ_reg;
    assign filled_cnt = filled_reg;

    // Pointer and count updates; a flush empties the queue in one cycle.
    always_comb begin
        alloc_ptr_next = alloc_ptr_reg;
        fill_ptr_next  = fill_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        occ_next       = occ_reg;
        filled_next    = filled_reg;
        if (flush) begin
            alloc_ptr_next = '0;
            fill_ptr_next  = '0;
            rd_ptr_next    = '0;
            occ_next       = '0;
            filled_next    = '0;
        end else begin
            if (alloc_en) begin
                alloc_ptr_next = alloc_ptr_reg + PTR_W'(1);
            end
            if (fill_en) begin
                fill_ptr_next = fill_ptr_reg + PTR_W'(1);
            end
            if (deq_en) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            occ_next    = occ_reg    + CNT_W'(alloc_en) - CNT_W'(deq_en);
            filled_next = filled_reg + CNT_W'(fill_en)  - CNT_W'(deq_en);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            filled_reg    <= '0;
        end else begin
            alloc_ptr_reg <= alloc_ptr_next;
            fill_ptr_reg  <= fill_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            occ_reg       <= occ_next;
            filled_reg    <= filled_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Holds the PC, issues in-order requests to
// instruction memory, buffers the returning instructions with their PCs and
// hands them to decode. A redirect reloads the PC, empties the queue and
// arranges for responses to already-issued requests to be discarded.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 64,
    parameter int          INST_W   = 32,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int STEP  = INST_W / 8;
    localparam int CNT_W = clog2_plus1(DEPTH);
    // Doomed responses from one redirect can overlap live requests issued
    // after it, so the drop and in-flight counters get one extra bit.
    localparam int DROP_W = CNT_W + 1;

    logic [ADDR_W-1:0] pc_reg,       pc_next;
    logic [DROP_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic [DROP_W-1:0] inflight_reg, inflight_next;

    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  filled_cnt;
    logic [CNT_W-1:0]  live_cnt;
    logic [ADDR_W-1:0] redirect_aligned;

    logic issue_fire;
    logic resp_drop;
    logic resp_fill;
    logic deq_fire;

    // Redirect targets are forced onto an instruction boundary.
    assign redirect_aligned = redirect_pc & ~ADDR_W'(STEP - 1);

    // Issue while there is a free entry; nothing issues during reset or redirect.
    assign imem_req_valid = !rst && !redirect_valid && (occupancy < CNT_W'(DEPTH));
    assign imem_req_addr  = pc_reg;
    assign issue_fire     = imem_req_valid && imem_req_ready;

    // Decode sees only filled entries, and never in a redirect cycle.
    assign out_valid = !rst && !redirect_valid && (filled_cnt != '0);
    assign deq_fire  = out_valid && out_ready;

    // Responses are discarded while drops are pending, otherwise written into the queue.
    assign resp_drop = imem_resp_valid && (drop_cnt_reg != '0);
    assign resp_fill = imem_resp_valid && (drop_cnt_reg == '0) && !redirect_valid && !rst;

    // Requests issued into the queue whose responses have not yet come back.
    assign live_cnt = occupancy - filled_cnt;

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect_valid),
        .alloc_en   (issue_fire),
        .alloc_pc   (pc_reg),
        .fill_en    (resp_fill),
        .fill_inst  (imem_resp_data),
        .deq_en     (deq_fire),
        .occupancy  (occupancy),
        .filled_cnt (filled_cnt),
        .head_pc    (out_pc),
        .head_inst  (out_inst)
    );

    // Next PC, pending-drop and in-flight bookkeeping.
    always_comb begin
        pc_next       = pc_reg;
        drop_cnt_next = drop_cnt_reg;
        inflight_next = inflight_reg + DROP_W'(issue_fire) - DROP_W'(imem_resp_valid);
        if (redirect_valid) begin
            pc_next = redirect_aligned;
            // Every live request becomes a drop; a response arriving now
            // settles one of the old or new drops immediately.
            drop_cnt_next = drop_cnt_reg + DROP_W'(live_cnt) - DROP_W'(imem_resp_valid);
        end else begin
            if (issue_fire) begin
                pc_next = pc_reg + ADDR_W'(STEP);
            end
            if (resp_drop) begin
                drop_cnt_next = drop_cnt_reg - DROP_W'(1);
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC[ADDR_W-1:0];
            drop_cnt_reg <= '0;
            inflight_reg <= '0;
        end else begin
            pc_reg       <= pc_next;
            drop_cnt_reg <= drop_cnt_next;
            inflight_reg <= inflight_next;
        end
    end

    // A response without any outstanding request indicates a broken memory port.
    always_ff @(posedge clk) begin
        if (!rst && imem_resp_valid) begin
            assert (inflight_reg != '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-configurable memory model answers
// requests in order, and a scoreboard of expected (pc, inst) pairs is pushed
// at request issue and popped at each decode handshake.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    fetch_unit #(
        .ADDR_W   (64),
        .INST_W   (32),
        .RESET_PC (RST_PC),
        .DEPTH    (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_inst        (out_inst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t     mem_q[$];
    fetch_entry_t sb[$];
    logic [63:0]  out_pcs[$];
    logic [63:0]  acc_addrs[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n_acc, n_out, first_req_cyc, first_out_cyc;
    logic [63:0] model_pc;
    logic        hold_valid;
    logic [63:0] hold_addr;
    logic [63:0] base_pc;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [63:0] out_pc_at(input int i);
        if (i < out_pcs.size()) return out_pcs[i];
        return 64'hx;
    endfunction

    function automatic logic [63:0] acc_addr_at(input int i);
        if (i < acc_addrs.size()) return acc_addrs[i];
        return 64'hx;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_track();
        n_acc = 0;
        n_out = 0;
        first_req_cyc = -1;
        first_out_cyc = -1;
        out_pcs.delete();
        acc_addrs.delete();
    endtask

    // One clock cycle: present the memory response, check the DUT outputs
    // for the handshakes that will happen at the coming edge, update models.
    task automatic tick();
        fetch_entry_t exp_e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
        #2;
        if (rst) begin
            chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
        end else if (redirect_valid) begin
            chk("redir_req_valid", 64'(imem_req_valid), 64'd0);
            chk("redir_out_valid", 64'(out_valid), 64'd0);
        end else begin
            if (hold_valid) begin
                chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
                chk("req_hold_addr", imem_req_addr, hold_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                $display("req  cyc=%0d addr=%h", cyc, imem_req_addr);
                chk("req_addr", imem_req_addr, model_pc);
                sb.push_back('{pc: model_pc, inst: inst_of(model_pc)});
                mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                n_acc++;
                acc_addrs.push_back(imem_req_addr);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                model_pc = model_pc + 64'(INST_BYTES);
            end
            if (out_valid && out_ready) begin
                $display("out  cyc=%0d pc=%h inst=%h", cyc, out_pc, out_inst);
                n_out++;
                out_pcs.push_back(out_pc);
                if (first_out_cyc < 0) first_out_cyc = cyc;
                total++;
                assert (sb.size() != 0) else begin
                    bad++;
                    $error("FAIL out_unexpected observed pc=%h expected no output", out_pc);
                end
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    chk("out_pc", out_pc, exp_e.pc);
                    chk("out_inst", {32'h0, out_inst}, {32'h0, exp_e.inst});
                end
            end
        end
        hold_valid = !rst && !redirect_valid && imem_req_valid && !imem_req_ready;
        hold_addr  = imem_req_addr;
        if (rst) begin
            sb.delete();
            model_pc = RST_PC;
        end else if (redirect_valid) begin
            sb.delete();
            model_pc = {redirect_pc[63:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Stop issuing and let every outstanding request and buffered entry drain.
    task automatic drain();
        imem_req_ready = 1'b0;
        out_ready      = 1'b1;
        for (int i = 0; i < 40 && (mem_q.size() != 0 || sb.size() != 0); i++) tick();
        chk("drain_empty", 64'(sb.size() + mem_q.size()), 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        out_ready      = 1'b1;
        model_pc       = RST_PC;
        hold_valid     = 1'b0;
        hold_addr      = '0;
        clear_track();

        // 1: reset, 1-cycle memory, streaming decode
        tick();
        tick();
        rst = 1'b0;
        lat = 1;
        clear_track();
        for (int i = 0; i < 10; i++) tick();
        chk("t1_latency", 64'(first_out_cyc - first_req_cyc), 64'd2);
        chk("t1_out_count", 64'(n_out), 64'd8);
        chk("t1_pc0", out_pc_at(0), 64'h0000_0000_8000_0000);
        chk("t1_pc2", out_pc_at(2), 64'h0000_0000_8000_0008);

        // 2: decode stalls, queue fills, then drains in order
        drain();
        base_pc = model_pc;
        clear_track();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("t2_acc_count", 64'(n_acc), 64'd4);
        chk("t2_req_blocked", 64'(imem_req_valid), 64'd0);
        clear_track();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t2_drain_pc0", out_pc_at(0), base_pc);
        chk("t2_drain_pc3", out_pc_at(3), base_pc + 64'd12);
        chk("t2_resume", 64'(n_acc != 0), 64'd1);

        // 3: 3-cycle memory, two requests in flight, misaligned redirect
        drain();
        lat = 3;
        out_ready      = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        tick();
        clear_track();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_1002;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("t3_pc0", out_pc_at(0), 64'h0000_0000_8000_1000);
        chk("t3_pc1", out_pc_at(1), 64'h0000_0000_8000_1004);
        chk("t3_drop_zero", 64'(dut.drop_cnt_reg), 64'd0);

        // 4: redirect with a full queue and a response in the same cycle
        drain();
        clear_track();
        imem_req_ready = 1'b1;
        out_ready      = 1'b0;
        for (int i = 0; i < 30 && n_acc < 4; i++) tick();
        chk("t4_full_acc", 64'(n_acc), 64'd4);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_2000;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("t4_drop_zero", 64'(dut.drop_cnt_reg), 64'd0);
        clear_track();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("t4_pc0", out_pc_at(0), 64'h0000_0000_8000_2000);
        chk("t4_pc1", out_pc_at(1), 64'h0000_0000_8000_2004);

        // 5: PC wraps past the top of the address space
        drain();
        lat = 1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        clear_track();
        for (int i = 0; i < 6; i++) tick();
        chk("t5_addr0", acc_addr_at(0), 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t5_wrap", acc_addr_at(1), 64'h0);

        // 6: reset mid-stream with three requests in flight
        drain();
        lat = 3;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        mem_q.delete();
        rst = 1'b0;
        clear_track();
        for (int i = 0; i < 10; i++) tick();
        chk("t6_pc0", out_pc_at(0), RST_PC);
        chk("t6_latency", 64'(first_out_cyc - first_req_cyc), 64'd4);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
